// File: rtl/fifo_datapath_param.sv
// Parametrised synchronous FIFO datapath with independent read/write
// pointers, occupancy count, programmable almost flags, sticky error
// flags and a synchronous flush. Single clock domain.
module fifo_datapath_param #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 5,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 Clear,
  input  logic [WIDTH-1:0]     DataIn,
  input  logic                 Write,
  input  logic                 Read,
  input  logic                 Flush,
  input  logic                 ClearErr,
  output logic [WIDTH-1:0]     DataOut,
  output logic                 DataValid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADD_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** ADD_WIDTH;
  localparam logic [ADD_WIDTH:0] C_DEPTH  = (ADD_WIDTH+1)'(DEPTH);
  localparam logic [ADD_WIDTH:0] C_AF_THR = (ADD_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADD_WIDTH:0] C_AE_THR = (ADD_WIDTH+1)'(AE_MARGIN);
  localparam logic [ADD_WIDTH:0] C_CNT_ONE = (ADD_WIDTH+1)'(1);
  localparam logic [ADD_WIDTH-1:0] C_PTR_ONE = ADD_WIDTH'(1);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADD_WIDTH-1:0] r_wptr;
  logic [ADD_WIDTH-1:0] r_rptr;
  logic [ADD_WIDTH:0]   r_count;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_dvalid;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_aempty;
  logic                 r_afull;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic [ADD_WIDTH:0]   w_count_nxt;

  // Acceptance uses only the registered full/empty flags.
  assign w_push_ok = Write & ~r_full  & ~Flush;
  assign w_pop_ok  = Read  & ~r_empty & ~Flush;
  assign w_ovf_evt = Write &  r_full  & ~Flush;
  assign w_unf_evt = Read  &  r_empty & ~Flush;

  // Next occupancy: flush wins, otherwise net of accepted push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (Flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + C_CNT_ONE;
        2'b01:   w_count_nxt = r_count - C_CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Storage array: written on accepted push, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= DataIn;
    end
  end

  // Pointers, count and flags; flags derive from the next count so they
  // line up with count in the same cycle.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (Flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + C_PTR_ONE;
        else           r_wptr <= r_wptr;
        if (w_pop_ok)  r_rptr <= r_rptr + C_PTR_ONE;
        else           r_rptr <= r_rptr;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == C_DEPTH);
      r_aempty <= (w_count_nxt <= C_AE_THR);
      r_afull  <= (w_count_nxt >= C_AF_THR);
    end
  end

  // Registered read port: one-cycle latency, DataOut holds when idle.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else if (w_pop_ok) begin
      r_dout   <= r_mem[r_rptr];
      r_dvalid <= 1'b1;
    end else begin
      r_dout   <= r_dout;
      r_dvalid <= 1'b0;
    end
  end

  // Sticky error flags; a new error beats a same-cycle ClearErr.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt)     r_ovf <= 1'b1;
      else if (ClearErr) r_ovf <= 1'b0;
      else               r_ovf <= r_ovf;
      if (w_unf_evt)     r_unf <= 1'b1;
      else if (ClearErr) r_unf <= 1'b0;
      else               r_unf <= r_unf;
    end
  end

  assign DataOut      = r_dout;
  assign DataValid    = r_dvalid;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_datapath_param.sv
// Scoreboard bench for fifo_datapath_param with default parameters.
// Stimulus queues expected popped words; a negedge monitor compares them
// whenever DataValid is high.
module tb_fifo_datapath_param;

  logic        clk;
  logic        Clear;
  logic [7:0]  DataIn;
  logic        Write;
  logic        Read;
  logic        Flush;
  logic        ClearErr;
  logic [7:0]  DataOut;
  logic        DataValid;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;
  logic [5:0]  count;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;
  int dv_pulses;
  logic [7:0] exp_q[$];
  logic [7:0] mdl[$];

  fifo_datapath_param #(.WIDTH(8), .ADD_WIDTH(5), .AF_MARGIN(4), .AE_MARGIN(4)) dut (
    .clk(clk), .Clear(Clear), .DataIn(DataIn), .Write(Write), .Read(Read),
    .Flush(Flush), .ClearErr(ClearErr), .DataOut(DataOut), .DataValid(DataValid),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DataValid pulse must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (DataValid === 1'b1) begin
        dv_pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv: got DataOut %0h expected no pulse at %0t", DataOut, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (DataOut !== e) begin
            errors++;
            $display("FAIL dataout: got %0h expected %0h at %0t", DataOut, e, $time);
          end
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; dv_pulses = 0;
    Clear = 1'b1; DataIn = 8'h00; Write = 1'b0; Read = 1'b0; Flush = 1'b0; ClearErr = 1'b0;
    step(); step();
    Clear = 1'b0;
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(DataOut), 32'd0);
    chk("rst_dv", 32'(DataValid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_full_af", 32'({full, almost_full}), 32'd0);

    // Fill 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      Write = 1'b1; DataIn = 8'(i);
      mdl.push_back(8'(i));
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 4));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 28));
      chk("fill_full", 32'(full), 32'((i + 1) == 32));
    end
    DataIn = 8'hAA;
    step();
    chk("ovf_count", 32'(count), 32'd32);
    chk("ovf_flag", 32'(overflow), 32'd1);
    Write = 1'b0;

    // Drain in order
    for (int i = 0; i < 32; i++) begin
      Read = 1'b1;
      exp_q.push_back(mdl.pop_front());
      step();
      chk("drain_count", 32'(count), 32'(31 - i));
      chk("drain_dv", 32'(DataValid), 32'd1);
    end
    step();
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dv", 32'(DataValid), 32'd0);
    chk("unf_empty", 32'(empty), 32'd1);
    Read = 1'b0;
    ClearErr = 1'b1;
    step();
    chk("clrerr1", 32'({overflow, underflow}), 32'd0);
    ClearErr = 1'b0;

    // Preload then concurrent traffic past the pointer wrap
    for (int i = 0; i < 3; i++) begin
      Write = 1'b1; DataIn = 8'(8'h40 + i);
      mdl.push_back(DataIn);
      step();
    end
    chk("preload_count", 32'(count), 32'd3);
    for (int i = 0; i < 40; i++) begin
      Write = 1'b1; Read = 1'b1; DataIn = 8'(8'h43 + i);
      exp_q.push_back(mdl.pop_front());
      mdl.push_back(DataIn);
      step();
      chk("conc_count", 32'(count), 32'd3);
    end
    Read = 1'b0;
    for (int i = 0; i < 29; i++) begin
      Write = 1'b1; DataIn = 8'(8'h80 + i);
      mdl.push_back(DataIn);
      step();
    end
    chk("refill_full", 32'({full, count}), 32'({1'b1, 6'd32}));
    Write = 1'b1; Read = 1'b1; DataIn = 8'hEE;
    exp_q.push_back(mdl.pop_front());
    step();
    chk("wr_at_full_count", 32'(count), 32'd31);
    chk("wr_at_full_ovf", 32'(overflow), 32'd1);
    chk("wr_at_full_full", 32'(full), 32'd0);
    Write = 1'b0; Read = 1'b0;

    // Flush alone, then refill to 10 and flush with Write+Read
    Flush = 1'b1;
    step();
    mdl.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_keep_ovf", 32'(overflow), 32'd1);
    Flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Write = 1'b1; DataIn = 8'(8'h10 + i);
      step();
    end
    chk("ten_count", 32'(count), 32'd10);
    Flush = 1'b1; Write = 1'b1; Read = 1'b1;
    step();
    chk("flushwr_count", 32'(count), 32'd0);
    chk("flushwr_empty", 32'({empty, almost_empty}), 32'd3);
    chk("flushwr_dv", 32'(DataValid), 32'd0);
    chk("flushwr_ovf", 32'(overflow), 32'd1);
    chk("flushwr_unf", 32'(underflow), 32'd0);
    chk("flushwr_dout_hold", 32'(DataOut), 32'h68);
    Flush = 1'b0; Write = 1'b0; Read = 1'b0;

    // Write+Read at empty: push only, underflow set, no read-through
    Write = 1'b1; Read = 1'b1; DataIn = 8'h5A;
    mdl.push_back(DataIn);
    step();
    chk("wr_at_empty_count", 32'(count), 32'd1);
    chk("wr_at_empty_unf", 32'(underflow), 32'd1);
    chk("wr_at_empty_dv", 32'(DataValid), 32'd0);
    Write = 1'b0; Read = 1'b0;
    ClearErr = 1'b1;
    step();
    chk("clrerr2", 32'({overflow, underflow}), 32'd0);
    ClearErr = 1'b0;
    Read = 1'b1;
    exp_q.push_back(mdl.pop_front());
    step();
    chk("pop5a_count", 32'(count), 32'd0);
    ClearErr = 1'b1;
    step();
    chk("err_beats_clr", 32'(underflow), 32'd1);
    Read = 1'b0;
    step();
    chk("clrerr3", 32'(underflow), 32'd0);
    ClearErr = 1'b0;

    // Async Clear mid-pop
    for (int i = 0; i < 5; i++) begin
      Write = 1'b1; DataIn = 8'(8'h30 + i);
      mdl.push_back(DataIn);
      step();
    end
    Write = 1'b0;
    chk("pre_async_count", 32'(count), 32'd5);
    Read = 1'b1;
    exp_q.push_back(mdl.pop_front());
    step();
    #5;
    Clear = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_dv", 32'(DataValid), 32'd0);
    chk("async_dout", 32'(DataOut), 32'd0);
    chk("async_flags", 32'({empty, almost_empty, full, almost_full}), 32'b1100);
    step();
    chk("async_hold_dv", 32'(DataValid), 32'd0);
    chk("async_hold_count", 32'(count), 32'd0);
    Clear = 1'b0; Read = 1'b0;
    mdl.delete();
    step();
    step();
    chk("end_count", 32'(count), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("dv_pulses", 32'(dv_pulses), 32'd75);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
